lif_neuron_array: RTL
=====================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 Parameter NEURONS, default 16: number of time-multiplexed excitatory neurons (2..256).
REQ-002 Parameter DW, default 16: fractional bits of potential and current.
REQ-003 Parameter INT_DW, default 8: integer bits; potential and current are signed, PW = DW+INT_DW bits.
REQ-004 Parameter REFRAC, default 5: refractory length, in time steps.
REQ-005 Parameters THRESH (default 24'h0d0000), INH_VAL (default 24'h3c0000), RESET_V (default 0): PW-bit signed constants.
REQ-006 clk  input  1  sole clock.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 en  input  1  global enable; when low, all state, including the FSM, holds.
REQ-009 step_start  input  1  pulse; begins one time step (a sweep over all neurons).
REQ-010 inh  input  1  global inhibition; sampled at step_start and applied to every neuron in that step.
REQ-011 in_valid / in_ready  input / output  1 / 1  input current handshake.
REQ-012 in_current  input  PW  signed synaptic current for the neuron currently being swept.
REQ-013 out_valid  output  1  result valid, one cycle only; no backpressure.
REQ-014 out_idx  output  clog2(NEURONS)  index of the neuron reported.
REQ-015 out_spike  output  1  neuron fired this step.
REQ-016 step_done  output  1  one-cycle pulse after the last neuron of a step is reported.
REQ-017 spike_cnt  output  32  total spikes since reset; wraps modulo 2^32.

Function
REQ-018 FSM states: IDLE, SWEEP, DONE. IDLE->SWEEP on step_start. SWEEP->DONE when neuron NEURONS-1 is accepted. DONE->IDLE after one cycle, with step_done=1.
REQ-019 in_ready=1 only in SWEEP with en=1. A transfer occurs when in_valid&in_ready. Each transfer processes neuron idx, then idx increments; idx resets to 0 on entering SWEEP.
REQ-020 step_start outside IDLE is ignored.
REQ-021 Per accepted neuron, when refrac_cnt!=0: potential holds, refrac_cnt decrements, spike=0.
REQ-022 Otherwise: p' = sat(potential + in_current - (inh_latched ? INH_VAL : 0)), computed at PW+2 bits and saturated to the signed PW range.
REQ-023 If p' >= THRESH (signed compare): spike=1, potential<=RESET_V, refrac_cnt<=REFRAC, spike_cnt increments. Otherwise potential<=p'.
REQ-024 out_valid, out_idx and out_spike appear on the cycle after the transfer (latency 1). State memory is written on that same edge.
REQ-025 The refractory counter is clog2(REFRAC+1) bits. REFRAC=0 gives no refractory period.
REQ-026 Back-to-back transfers are accepted every cycle. Gaps in in_valid stall the sweep without losing state.
REQ-027 step_done asserts exactly one cycle after the final out_valid.

Reset
REQ-028 rst sets: all potentials to RESET_V, all refrac_cnt to 0, spike_cnt, out_valid, out_spike, out_idx, step_done and idx to 0, FSM to IDLE. rst overrides en.
REQ-029 rst asserted mid-sweep abandons the step. No step_done is produced for it.

Configuration
REQ-030 Macro LIF_LEAK_EN. When defined, add parameter LEAK_SH (default 4) and subtract potential>>>LEAK_SH (arithmetic shift) inside the REQ-022 sum, for non-refractory neurons only.
REQ-031 Without LIF_LEAK_EN there is no leak term and no LEAK_SH parameter; behaviour is exactly REQ-022.

Structure
REQ-032 Package lif_pkg holds: the FSM state enum, the PW-width potential type, and the saturation limits.
REQ-033 Sub-module lif_update is the combinational single-neuron update (REQ-021..023, REQ-030). Inputs: potential, refrac, current, inh. Outputs: next potential, next refrac, spike.
REQ-034 State storage is a NEURONS-deep register array indexed by idx. Reading it is combinational.

Verification
REQ-035 Reset, then step with in_current=0x010000 for all 16 neurons -> 16 out_valid, out_spike=0, step_done once, spike_cnt=0.
REQ-036 Neuron 3 fed 0x070000 for two steps -> spike in step 2 (0x0e0000 >= 0x0d0000); neuron 3 potential=0; spike_cnt=1.
REQ-037 Same as REQ-036, then feed 0x0d0000 for six more steps with REFRAC=5 -> no spike for steps 3-7; spike in step 8.
REQ-038 inh=1 at step_start, in_current=0 -> every potential becomes -0x3c0000. Repeat until saturated -> potential clamps at 0x800000 with no wrap.
REQ-039 in_valid toggles 1,0,1,0 during a sweep, and rst is asserted at neuron 7 -> outputs carry gap-free indices; after rst all state is zero and FSM is IDLE with no step_done.
REQ-040 With LIF_LEAK_EN and LEAK_SH=4: potential 0x080000, current 0 -> next potential 0x078000.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared types and constants for the time-multiplexed LIF neuron array.
package lif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } lif_state_e;

  localparam int unsigned LIF_PW = 24;

  typedef logic signed [LIF_PW-1:0] lif_pot_t;

  localparam lif_pot_t POT_MAX = {1'b0, {(LIF_PW-1){1'b1}}};
  localparam lif_pot_t POT_MIN = {1'b1, {(LIF_PW-1){1'b0}}};

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron LIF update: refractory countdown, saturating integrate, fire/reset.
// Optional leak term enabled by the LIF_LEAK_EN macro.
module lif_update
  import lif_pkg::*;
#(
  parameter int unsigned        PW      = 24,
  parameter int unsigned        RW      = 3,
  parameter int unsigned        REFRAC  = 5,
  parameter logic signed [PW-1:0] THRESH  = 24'sh0d0000,
  parameter logic signed [PW-1:0] INH_VAL = 24'sh3c0000,
  parameter logic signed [PW-1:0] RESET_V = '0
`ifdef LIF_LEAK_EN
  ,
  parameter int unsigned        LEAK_SH = 4
`endif
) (
  input  logic signed [PW-1:0] pot_i,
  input  logic        [RW-1:0] refrac_i,
  input  logic signed [PW-1:0] cur_i,
  input  logic                 inh_i,
  output logic signed [PW-1:0] pot_o,
  output logic        [RW-1:0] refrac_o,
  output logic                 spike_o
);

  localparam logic signed [PW+1:0] SMAX = {3'b000, {(PW-1){1'b1}}};
  localparam logic signed [PW+1:0] SMIN = {3'b111, {(PW-1){1'b0}}};

  logic signed [PW+1:0] pot_ext;
  logic signed [PW+1:0] sum;
  logic signed [PW-1:0] sat;

  always_comb begin
    pot_ext = {{2{pot_i[PW-1]}}, pot_i};
    sum     = pot_ext + {{2{cur_i[PW-1]}}, cur_i};
    if (inh_i) begin
      sum = sum - {{2{INH_VAL[PW-1]}}, INH_VAL};
    end
`ifdef LIF_LEAK_EN
    sum = sum - (pot_ext >>> LEAK_SH);
`endif
    if (sum > SMAX) begin
      sat = SMAX[PW-1:0];
    end else if (sum < SMIN) begin
      sat = SMIN[PW-1:0];
    end else begin
      sat = sum[PW-1:0];
    end

    pot_o    = pot_i;
    refrac_o = refrac_i;
    spike_o  = 1'b0;
    if (refrac_i != '0) begin
      refrac_o = refrac_i - 1'b1;
    end else if (sat >= THRESH) begin
      spike_o  = 1'b1;
      pot_o    = RESET_V;
      refrac_o = RW'(REFRAC);
    end else begin
      pot_o = sat;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of NEURONS leaky integrate-and-fire neurons swept once per step.
// Build with LIF_LEAK_EN defined to add the potential leak term (LEAK_SH parameter).
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int unsigned NEURONS = 16,
  parameter int unsigned DW      = 16,
  parameter int unsigned INT_DW  = 8,
  parameter int unsigned REFRAC  = 5,
  parameter logic signed [DW+INT_DW-1:0] THRESH  = 24'sh0d0000,
  parameter logic signed [DW+INT_DW-1:0] INH_VAL = 24'sh3c0000,
  parameter logic signed [DW+INT_DW-1:0] RESET_V = '0
`ifdef LIF_LEAK_EN
  ,
  parameter int unsigned LEAK_SH = 4
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          step_start,
  input  logic                          inh,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DW+INT_DW-1:0]   in_current,
  output logic                          out_valid,
  output logic [$clog2(NEURONS)-1:0]    out_idx,
  output logic                          out_spike,
  output logic                          step_done,
  output logic [31:0]                   spike_cnt
);

  localparam int unsigned PW = DW + INT_DW;
  localparam int unsigned IW = $clog2(NEURONS);
  localparam int unsigned RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [IW-1:0] LAST = IW'(NEURONS - 1);

  lif_state_e state_q, state_d;

  logic signed [PW-1:0] pot_q [NEURONS];
  logic        [RW-1:0] ref_q [NEURONS];
  logic [IW-1:0]        idx_q;
  logic                 inh_q;
  logic                 out_valid_q;
  logic [IW-1:0]        out_idx_q;
  logic                 out_spike_q;
  logic                 step_done_q;
  logic [31:0]          spike_cnt_q;

  logic                 xfer;
  logic signed [PW-1:0] upd_pot;
  logic        [RW-1:0] upd_ref;
  logic                 upd_spike;

  assign in_ready = (state_q == SWEEP) && en;
  assign xfer     = in_ready && in_valid;

  lif_update #(
    .PW      (PW),
    .RW      (RW),
    .REFRAC  (REFRAC),
    .THRESH  (THRESH),
    .INH_VAL (INH_VAL),
    .RESET_V (RESET_V)
`ifdef LIF_LEAK_EN
    ,
    .LEAK_SH (LEAK_SH)
`endif
  ) u_update (
    .pot_i    (pot_q[idx_q]),
    .refrac_i (ref_q[idx_q]),
    .cur_i    (in_current),
    .inh_i    (inh_q),
    .pot_o    (upd_pot),
    .refrac_o (upd_ref),
    .spike_o  (upd_spike)
  );

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        IDLE:    if (step_start) state_d = SWEEP;
        SWEEP:   if (xfer && idx_q == LAST) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NEURONS; i++) begin
        pot_q[i] <= RESET_V;
        ref_q[i] <= '0;
      end
      idx_q       <= '0;
      inh_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_spike_q <= 1'b0;
      step_done_q <= 1'b0;
      spike_cnt_q <= '0;
    end else if (en) begin
      out_valid_q <= xfer;
      out_spike_q <= xfer && upd_spike;
      // step_done follows the DONE cycle, i.e. one cycle after the final out_valid
      step_done_q <= (state_q == DONE);
      if (state_q == IDLE && step_start) begin
        idx_q <= '0;
        inh_q <= inh;
      end
      if (xfer) begin
        pot_q[idx_q] <= upd_pot;
        ref_q[idx_q] <= upd_ref;
        out_idx_q    <= idx_q;
        idx_q        <= (idx_q == LAST) ? '0 : idx_q + 1'b1;
        if (upd_spike) spike_cnt_q <= spike_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_spike = out_spike_q;
  assign step_done = step_done_q;
  assign spike_cnt = spike_cnt_q;

endmodule
